// File: rtl/demux_stream.sv
// demux_stream: routes one input stream to one of two output channels,
//   chosen by S (mode 0) or by an alternating pointer (mode 1).
// Latency: 1 cycle from input transfer to O0_valid / O1_valid.
// Backpressure: in_ready follows only the target channel. A full channel
//   can be drained and refilled in the same cycle, so no bubble is inserted.
// Ports:
//   clk, rst_n           clock, async active-low reset
//   mode, S              routing mode and channel select for mode 0
//   in_valid/in_ready/in_data        input stream
//   O0_valid/O0_ready/O0_data        channel 0 stream
//   O1_valid/O1_ready/O1_data        channel 1 stream
//   ptr                  alternation pointer (0 = ROUTE0, 1 = ROUTE1)
//   cnt0, cnt1           words accepted per channel, 8-bit, wrapping
module demux_stream #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mode,
  input  logic             S,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             O0_valid,
  output logic [WIDTH-1:0] O0_data,
  input  logic             O0_ready,
  output logic             O1_valid,
  output logic [WIDTH-1:0] O1_data,
  input  logic             O1_ready,
  output logic             ptr,
  output logic [7:0]       cnt0,
  output logic [7:0]       cnt1
);

  typedef enum logic {
    ROUTE0 = 1'b0,
    ROUTE1 = 1'b1
  } ptr_state_t;

  ptr_state_t state;
  ptr_state_t state_next;

  logic tgt;
  logic xfer;
  logic load0;
  logic load1;

  // Target channel index: S in mode 0, the pointer in mode 1.
  assign tgt = mode ? (state == ROUTE1) : S;

  // Readiness looks only at the target channel; the other channel never
  // stalls the input.
  assign in_ready = tgt ? (~O1_valid | O1_ready) : (~O0_valid | O0_ready);

  assign xfer  = in_valid & in_ready;
  assign load0 = xfer & ~tgt;
  assign load1 = xfer & tgt;

  assign ptr = (state == ROUTE1);

  // Pointer FSM: it toggles only on transfers made in mode 1. In mode 0 it
  // holds, so switching back to mode 1 resumes the alternation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ROUTE0;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if (mode && xfer) begin
      case (state)
        ROUTE0:  state_next = ROUTE1;
        ROUTE1:  state_next = ROUTE0;
        default: state_next = ROUTE0;
      endcase
    end
  end

  // Channel 0 holding register. A load takes priority over a drain, so a
  // word consumed in the same cycle as a refill is simply replaced.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      O0_valid <= 1'b0;
      O0_data  <= '0;
      cnt0     <= 8'd0;
    end else begin
      if (load0) begin
        O0_valid <= 1'b1;
        O0_data  <= in_data;
        cnt0     <= cnt0 + 8'd1;
      end else if (O0_valid && O0_ready) begin
        O0_valid <= 1'b0;
      end
    end
  end

  // Channel 1 holding register, same structure as channel 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      O1_valid <= 1'b0;
      O1_data  <= '0;
      cnt1     <= 8'd0;
    end else begin
      if (load1) begin
        O1_valid <= 1'b1;
        O1_data  <= in_data;
        cnt1     <= cnt1 + 8'd1;
      end else if (O1_valid && O1_ready) begin
        O1_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_demux_stream.sv
// tb_demux_stream: directed checks of demux_stream routing, backpressure,
//   drain/refill, pointer alternation, counter wrap and async reset.
// Inputs change 1 time unit after the rising edge; outputs are read there.
module tb_demux_stream;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         mode;
  logic         S;
  logic         in_valid;
  logic [W-1:0] in_data;
  logic         in_ready;
  logic         O0_valid;
  logic [W-1:0] O0_data;
  logic         O0_ready;
  logic         O1_valid;
  logic [W-1:0] O1_data;
  logic         O1_ready;
  logic         ptr;
  logic [7:0]   cnt0;
  logic [7:0]   cnt1;

  int checks;
  int failures;

  demux_stream #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .mode     (mode),
    .S        (S),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .O0_valid (O0_valid),
    .O0_data  (O0_data),
    .O0_ready (O0_ready),
    .O1_valid (O1_valid),
    .O1_data  (O1_data),
    .O1_ready (O1_ready),
    .ptr      (ptr),
    .cnt0     (cnt0),
    .cnt1     (cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic do_reset();
    in_valid = 1'b0;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; mode = 1'b0; S = 1'b0; in_valid = 1'b0; in_data = '0;
    O0_ready = 1'b0; O1_ready = 1'b0;
    #3;
    checks++;
    if ({O0_valid, O1_valid, ptr} !== 3'b000) begin
      failures++;
      $display("FAIL reset_valid_ptr: got %b expected 000", {O0_valid, O1_valid, ptr});
    end
    checks++;
    if ({cnt0, cnt1} !== 16'h0000 || O0_data !== 8'h00 || O1_data !== 8'h00) begin
      failures++;
      $display("FAIL reset_cnt_data: cnt0=%0d cnt1=%0d d0=%h d1=%h expected all 0",
               cnt0, cnt1, O0_data, O1_data);
    end
    step();
    rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    end
  endtask

  task automatic test_route_select();
    do_reset();
    mode = 1'b0; S = 1'b1; O1_ready = 1'b1; O0_ready = 1'b0;
    in_valid = 1'b1; in_data = 8'h01;
    step();
    in_valid = 1'b0;
    checks++;
    if (O1_valid !== 1'b1 || O1_data !== 8'h01 || cnt1 !== 8'd1) begin
      failures++;
      $display("FAIL route_s1: O1_valid=%b O1_data=%h cnt1=%0d expected 1/01/1",
               O1_valid, O1_data, cnt1);
    end
    checks++;
    if (O0_valid !== 1'b0 || cnt0 !== 8'd0) begin
      failures++;
      $display("FAIL route_s1_other: O0_valid=%b cnt0=%0d expected 0/0", O0_valid, cnt0);
    end
    step();
    checks++;
    if (O1_valid !== 1'b0 || O1_data !== 8'h01) begin
      failures++;
      $display("FAIL route_s1_drain: O1_valid=%b O1_data=%h expected 0/01", O1_valid, O1_data);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    mode = 1'b0; S = 1'b0; O0_ready = 1'b0; O1_ready = 1'b0;
    in_valid = 1'b1; in_data = 8'hA5;
    step();
    in_data = 8'h3C;
    checks++;
    if (in_ready !== 1'b0 || O0_valid !== 1'b1 || O0_data !== 8'hA5) begin
      failures++;
      $display("FAIL bp_first: in_ready=%b O0_valid=%b O0_data=%h expected 0/1/a5",
               in_ready, O0_valid, O0_data);
    end
    // Non-target channel is empty, so switching the target frees the input.
    S = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL bp_other_channel: in_ready=%b expected 1", in_ready);
    end
    S = 1'b0;
    step();
    checks++;
    if (in_ready !== 1'b0 || O0_data !== 8'hA5 || cnt0 !== 8'd1) begin
      failures++;
      $display("FAIL bp_hold: in_ready=%b O0_data=%h cnt0=%0d expected 0/a5/1",
               in_ready, O0_data, cnt0);
    end
    O0_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL bp_release: in_ready=%b expected 1", in_ready);
    end
    step();
    in_valid = 1'b0;
    checks++;
    if (O0_valid !== 1'b1 || O0_data !== 8'h3C || cnt0 !== 8'd2) begin
      failures++;
      $display("FAIL bp_second: O0_valid=%b O0_data=%h cnt0=%0d expected 1/3c/2",
               O0_valid, O0_data, cnt0);
    end
    step();
    checks++;
    if (O0_valid !== 1'b0) begin
      failures++;
      $display("FAIL bp_drained: O0_valid=%b expected 0", O0_valid);
    end
  endtask

  task automatic test_alternate();
    logic [3:0] exp_v0;
    logic [3:0] exp_v1;
    logic [3:0] exp_ptr;
    do_reset();
    exp_v0  = 4'b0101;  // per cycle i, bit i
    exp_v1  = 4'b1010;
    exp_ptr = 4'b0101;
    mode = 1'b1; O0_ready = 1'b1; O1_ready = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data = 8'h10 + 8'(i);
      step();
      checks++;
      if (O0_valid !== exp_v0[i] || O1_valid !== exp_v1[i] || ptr !== exp_ptr[i] ||
          (exp_v0[i] && O0_data !== 8'h10 + 8'(i)) ||
          (exp_v1[i] && O1_data !== 8'h10 + 8'(i))) begin
        failures++;
        $display("FAIL alt_word%0d: v0=%b v1=%b ptr=%b d0=%h d1=%h expected v0=%b v1=%b ptr=%b data=%h",
                 i, O0_valid, O1_valid, ptr, O0_data, O1_data,
                 exp_v0[i], exp_v1[i], exp_ptr[i], 8'h10 + 8'(i));
      end
    end
    in_valid = 1'b0;
    checks++;
    if (ptr !== 1'b0 || cnt0 !== 8'd2 || cnt1 !== 8'd2) begin
      failures++;
      $display("FAIL alt_end: ptr=%b cnt0=%0d cnt1=%0d expected 0/2/2", ptr, cnt0, cnt1);
    end
    // One word in mode 1 moves ptr to ROUTE1; mode 0 words must not move it.
    in_valid = 1'b1; in_data = 8'h20;
    step();
    mode = 1'b0; S = 1'b0; in_data = 8'h21;
    step();
    in_valid = 1'b0;
    checks++;
    if (ptr !== 1'b1 || cnt0 !== 8'd4) begin
      failures++;
      $display("FAIL alt_mode0_hold: ptr=%b cnt0=%0d expected 1/4", ptr, cnt0);
    end
    mode = 1'b1; in_valid = 1'b1; in_data = 8'h22;
    step();
    in_valid = 1'b0;
    checks++;
    if (O1_valid !== 1'b1 || O1_data !== 8'h22 || ptr !== 1'b0 || cnt1 !== 8'd3) begin
      failures++;
      $display("FAIL alt_resume: O1_valid=%b O1_data=%h ptr=%b cnt1=%0d expected 1/22/0/3",
               O1_valid, O1_data, ptr, cnt1);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    mode = 1'b0; S = 1'b0; O0_ready = 1'b0; O1_ready = 1'b0;
    in_valid = 1'b1; in_data = 8'h55;
    step();
    O0_ready = 1'b1; in_data = 8'h66;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL b2b_ready: in_ready=%b expected 1", in_ready);
    end
    step();
    in_valid = 1'b0;
    checks++;
    if (O0_valid !== 1'b1 || O0_data !== 8'h66 || cnt0 !== 8'd2) begin
      failures++;
      $display("FAIL b2b_refill: O0_valid=%b O0_data=%h cnt0=%0d expected 1/66/2",
               O0_valid, O0_data, cnt0);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    mode = 1'b0; S = 1'b1; O1_ready = 1'b1; O0_ready = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 255; i++) begin
      in_data = 8'(i);
      step();
    end
    checks++;
    if (cnt1 !== 8'd255 || O1_data !== 8'd254) begin
      failures++;
      $display("FAIL wrap_255: cnt1=%0d O1_data=%h expected 255/fe", cnt1, O1_data);
    end
    in_data = 8'hFF;
    step();
    in_valid = 1'b0;
    checks++;
    if (cnt1 !== 8'd0 || O1_data !== 8'hFF || cnt0 !== 8'd0) begin
      failures++;
      $display("FAIL wrap_0: cnt1=%0d O1_data=%h cnt0=%0d expected 0/ff/0", cnt1, O1_data, cnt0);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    O0_ready = 1'b0; O1_ready = 1'b0;
    mode = 1'b1; in_valid = 1'b1; in_data = 8'h77;
    step();
    mode = 1'b0; S = 1'b1; in_data = 8'h88;
    step();
    in_valid = 1'b0;
    checks++;
    if ({O0_valid, O1_valid, ptr} !== 3'b111) begin
      failures++;
      $display("FAIL arst_setup: v0 v1 ptr=%b expected 111", {O0_valid, O1_valid, ptr});
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({O0_valid, O1_valid, ptr} !== 3'b000 || cnt0 !== 8'd0 || cnt1 !== 8'd0 ||
        O0_data !== 8'h00 || O1_data !== 8'h00) begin
      failures++;
      $display("FAIL arst_clear: v0=%b v1=%b ptr=%b cnt0=%0d cnt1=%0d d0=%h d1=%h expected all 0",
               O0_valid, O1_valid, ptr, cnt0, cnt1, O0_data, O1_data);
    end
    #1;
    rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1 || O0_valid !== 1'b0) begin
      failures++;
      $display("FAIL arst_after: in_ready=%b O0_valid=%b expected 1/0", in_ready, O0_valid);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_route_select();
    test_backpressure();
    test_alternate();
    test_back_to_back();
    test_wrap();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/demux_stream.md
DEMUX_STREAM -- requirements
Module: demux_stream

Interface
REQ-001 Parameter: WIDTH, default 1, data width of input and both output channels.
REQ-002 Port: clk  input  1  single clock; all state changes on rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: mode  input  1  0 = route by S, 1 = alternate routing by internal pointer.
REQ-005 Port: S  input  1  channel select in mode 0 (0 -> channel 0, 1 -> channel 1).
REQ-006 Port: in_valid  input  1  input word present.
REQ-007 Port: in_data  input  WIDTH  input word.
REQ-008 Port: in_ready  output  1  block can accept the word this cycle.
REQ-009 Port: O0_valid / O1_valid  output  1 each  channel holds a word.
REQ-010 Port: O0_data / O1_data  output  WIDTH each  channel word.
REQ-011 Port: O0_ready / O1_ready  input  1 each  channel consumer accepts.
REQ-012 Port: ptr  output  1  current pointer state (0 = ROUTE0, 1 = ROUTE1).
REQ-013 Port: cnt0 / cnt1  output  8 each  words accepted into channel 0 / 1.

Function
REQ-014 Target channel: mode 0 -> S; mode 1 -> ptr; both sampled in the transfer cycle.
REQ-015 Input transfer = in_valid & in_ready on a rising edge.
REQ-016 in_ready = ~Ox_valid | Ox_ready for target channel x; combinational; independent of the non-target channel.
REQ-017 On input transfer, in_data is registered into the target channel's holding register; Ox_valid = 1 from the next cycle (latency 1 cycle).
REQ-018 Output transfer on channel x = Ox_valid & Ox_ready; Ox_valid clears next cycle unless that channel is refilled in the same cycle.
REQ-019 Simultaneous drain and refill of one channel: new word replaces old, Ox_valid stays 1, no bubble.
REQ-020 Ox_data holds its value while Ox_valid = 1 and Ox_ready = 0.
REQ-021 Ox_data is unchanged when Ox_valid = 0; it is not required to be zero.
REQ-022 Non-target channel: state unchanged by input activity; it drains independently.
REQ-023 Pointer FSM states: ROUTE0, ROUTE1.
REQ-024 Pointer transitions: in mode 1, toggles on each input transfer; otherwise holds.
REQ-025 Pointer in mode 0: holds value; on switch to mode 1, resumes from the held state.
REQ-026 cntx increments by 1 on each input transfer into channel x; wraps 255 -> 0; no saturation.
REQ-027 No word is dropped or duplicated: each input transfer produces exactly one output transfer on its target channel.

Reset
REQ-028 rst_n = 0 immediately (asynchronously) forces O0_valid = O1_valid = 0, ptr = ROUTE0, cnt0 = cnt1 = 0.
REQ-029 O0_data / O1_data reset to 0.
REQ-030 Reset mid-operation discards held words; no output transfer completes in the reset cycle.
REQ-031 After rst_n deasserts, in_ready = 1 in the first cycle, since both channels are empty.

Verification
REQ-032 Mode 0, S = 1, in_data = 1, O1_ready = 1 -> O1_valid = 1, O1_data = 1 next cycle; cnt1 = 1; O0_valid stays 0.
REQ-033 Mode 0, S = 0, O0_ready = 0, two valid words -> first accepted; in_ready = 0 on the second until O0_ready = 1; O0_data holds the first word.
REQ-034 Mode 1, in_valid held 1, both ready = 1, 4 words -> routed to channels 0, 1, 0, 1; ptr ends at ROUTE0; cnt0 = cnt1 = 2.
REQ-035 Channel 0 full with O0_ready = 1 and a new word targeted at channel 0 -> old word consumed and new word loaded in the same cycle; O0_valid stays 1.
REQ-036 256 accepted words on channel 1 -> cnt1 wraps to 0.
REQ-037 Pulse rst_n low asynchronously while O0_valid = O1_valid = 1 -> both valids 0, counters 0, ptr = 0 without a clock edge.
